// File: rtl/dram_axi_responder.sv
// DRAM-side AXI-lite responder: word-addressed 64-bit memory with programmable
// read/write latency, one outstanding transaction at a time.
module dram_axi_responder #(
    parameter logic [16:0] BASE_ADDR = 17'h10000,
    parameter int          DEPTH     = 256,
    parameter int          RD_LAT    = 2,
    parameter int          WR_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        AR_VALID,
    input  logic [16:0] AR_ADDR,
    output logic        AR_READY,
    output logic        R_VALID,
    output logic [63:0] R_DATA,
    output logic [1:0]  R_RESP,
    input  logic        R_READY,
    input  logic        AW_VALID,
    input  logic [16:0] AW_ADDR,
    output logic        AW_READY,
    input  logic        W_VALID,
    input  logic [63:0] W_DATA,
    output logic        W_READY,
    output logic        B_VALID,
    output logic [1:0]  B_RESP,
    input  logic        B_READY
);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_LAT_WAIT, RD_RESP, WR_DATA, WR_LAT_WAIT, WR_RESP
    } state_t;

    logic [63:0] mem [0:DEPTH-1];

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [IDX_W-1:0]   rd_idx_reg, rd_idx_next, wr_idx_reg, wr_idx_next;
    logic               rd_ok_reg, rd_ok_next, wr_ok_reg, wr_ok_next;
    logic               ar_ready_reg, ar_ready_next, aw_ready_reg, aw_ready_next;
    logic               w_ready_reg, w_ready_next;
    logic               r_valid_reg, r_valid_next, b_valid_reg, b_valid_next;
    logic [1:0]         r_resp_reg, r_resp_next, b_resp_reg, b_resp_next;
    logic [63:0]        r_data_reg;
    logic               r_load, b_load;
    logic               ar_hs, aw_hs, w_hs, r_hs, b_hs;

    // Range and alignment are judged on the raw address, so the subtraction
    // result is only ever used for addresses at or above BASE_ADDR.
    function automatic logic addr_ok(input logic [16:0] addr);
        logic [16:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && (addr[2:0] == 3'b000) && (32'(off >> 3) < DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [16:0] addr);
        logic [16:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 3);
    endfunction

    // Read wins a simultaneous AR/AW: AW_READY is masked while AR_VALID is up.
    assign ar_hs = ar_ready_reg & AR_VALID;
    assign aw_hs = aw_ready_reg & AW_VALID & ~AR_VALID;
    assign w_hs  = w_ready_reg & W_VALID;
    assign r_hs  = r_valid_reg & R_READY;
    assign b_hs  = b_valid_reg & B_READY;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rd_idx_next = rd_idx_reg;
        rd_ok_next  = rd_ok_reg;
        wr_idx_next = wr_idx_reg;
        wr_ok_next  = wr_ok_reg;
        unique case (state_reg)
            IDLE: begin
                if (ar_hs) begin
                    rd_idx_next = addr_idx(AR_ADDR);
                    rd_ok_next  = addr_ok(AR_ADDR);
                    cnt_next    = '0;
                    state_next  = (RD_LAT == 0) ? RD_RESP : RD_LAT_WAIT;
                end else if (aw_hs) begin
                    wr_idx_next = addr_idx(AW_ADDR);
                    wr_ok_next  = addr_ok(AW_ADDR);
                    state_next  = WR_DATA;
                end
            end
            RD_LAT_WAIT: begin
                if (cnt_reg == CNT_W'(RD_LAT - 1)) state_next = RD_RESP;
                else                               cnt_next   = cnt_reg + 1'b1;
            end
            RD_RESP: if (r_hs) state_next = IDLE;
            WR_DATA: begin
                if (w_hs) begin
                    cnt_next   = '0;
                    state_next = (WR_LAT == 0) ? WR_RESP : WR_LAT_WAIT;
                end
            end
            WR_LAT_WAIT: begin
                if (cnt_reg == CNT_W'(WR_LAT - 1)) state_next = WR_RESP;
                else                               cnt_next   = cnt_reg + 1'b1;
            end
            WR_RESP: if (b_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        ar_ready_next = (state_next == IDLE);
        aw_ready_next = (state_next == IDLE);
        w_ready_next  = (state_next == WR_DATA);
        r_valid_next  = (state_next == RD_RESP);
        b_valid_next  = (state_next == WR_RESP);
        r_load        = (state_next == RD_RESP) && (state_reg != RD_RESP);
        b_load        = (state_next == WR_RESP) && (state_reg != WR_RESP);

        r_resp_next = r_resp_reg;
        if (r_load)                       r_resp_next = rd_ok_next ? 2'b00 : 2'b10;
        else if (state_next != RD_RESP)   r_resp_next = 2'b00;
        b_resp_next = b_resp_reg;
        if (b_load)                       b_resp_next = wr_ok_reg ? 2'b00 : 2'b10;
        else if (state_next != WR_RESP)   b_resp_next = 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            rd_idx_reg   <= '0;
            rd_ok_reg    <= 1'b0;
            wr_idx_reg   <= '0;
            wr_ok_reg    <= 1'b0;
            ar_ready_reg <= 1'b0;
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b0;
            r_valid_reg  <= 1'b0;
            b_valid_reg  <= 1'b0;
            r_resp_reg   <= 2'b00;
            b_resp_reg   <= 2'b00;
            r_data_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            rd_idx_reg   <= rd_idx_next;
            rd_ok_reg    <= rd_ok_next;
            wr_idx_reg   <= wr_idx_next;
            wr_ok_reg    <= wr_ok_next;
            ar_ready_reg <= ar_ready_next;
            aw_ready_reg <= aw_ready_next;
            w_ready_reg  <= w_ready_next;
            r_valid_reg  <= r_valid_next;
            b_valid_reg  <= b_valid_next;
            r_resp_reg   <= r_resp_next;
            b_resp_reg   <= b_resp_next;
            if (r_load)                     r_data_reg <= rd_ok_next ? mem[rd_idx_next] : '0;
            else if (state_next != RD_RESP) r_data_reg <= '0;
        end
    end

    // Memory is never reset; an accepted write commits on its W edge.
    always_ff @(posedge clk) begin
        if (w_hs && wr_ok_reg) mem[wr_idx_reg] <= W_DATA;
    end

    assign AR_READY = ar_ready_reg;
    assign AW_READY = aw_ready_reg & ~AR_VALID;
    assign W_READY  = w_ready_reg;
    assign R_VALID  = r_valid_reg;
    assign R_DATA   = r_data_reg;
    assign R_RESP   = r_resp_reg;
    assign B_VALID  = b_valid_reg;
    assign B_RESP   = b_resp_reg;
endmodule

// File: tb/tb_dram_axi_responder.sv
// Directed bench for dram_axi_responder: latency, decode errors, boundaries,
// backpressure, AR/AW priority and reset during a read.
module tb_dram_axi_responder;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic        clk, rst;
    logic        AR_VALID, AR_READY, R_VALID, R_READY;
    logic [16:0] AR_ADDR, AW_ADDR;
    logic [63:0] R_DATA, W_DATA;
    logic [1:0]  R_RESP, B_RESP;
    logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;

    int checks   = 0;
    int failures = 0;

    dram_axi_responder #(
        .BASE_ADDR(17'h10000), .DEPTH(256), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
        .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ar_ready"}, AR_READY, 0);
        check({tag, "_aw_ready"}, AW_READY, 0);
        check({tag, "_w_ready"},  W_READY,  0);
        check({tag, "_r_valid"},  R_VALID,  0);
        check({tag, "_r_data"},   R_DATA,   0);
        check({tag, "_r_resp"},   R_RESP,   0);
        check({tag, "_b_valid"},  B_VALID,  0);
        check({tag, "_b_resp"},   B_RESP,   0);
    endtask

    // Issues AR and returns at the first negedge after the AR handshake.
    task automatic ar_phase(input logic [16:0] addr);
        int n;
        AR_ADDR  = addr;
        AR_VALID = 1'b1;
        n = 0;
        while (AR_READY !== 1'b1 && n < 20) begin tick(); n++; end
        check("ar_ready_wait", AR_READY, 1);
        tick();
        AR_VALID = 1'b0;
        AR_ADDR  = '0;
        check("ar_ready_drop", AR_READY, 0);
    endtask

    // Waits for R, optionally holding R_READY low for 'hold' cycles of R_VALID.
    task automatic r_phase(input logic [1:0] exp_resp, input logic [63:0] exp_data,
                           input bit chk_data, input int hold);
        int n;
        R_READY = (hold == 0);
        n = 1;
        while (R_VALID !== 1'b1 && n < 20) begin tick(); n++; end
        check("rd_latency", n, 1 + RD_LAT);
        check("r_resp", R_RESP, exp_resp);
        if (chk_data) check("r_data", R_DATA, exp_data);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("bp_r_valid", R_VALID, 1);
            if (chk_data) check("bp_r_data", R_DATA, exp_data);
            check("bp_ar_ready", AR_READY, 0);
        end
        R_READY = 1'b1;
        tick();
        check("r_valid_clear", R_VALID, 0);
        check("r_data_clear", R_DATA, 0);
        check("ar_ready_back", AR_READY, 1);
        R_READY = 1'b0;
        $display("read  resp=%b data=%h hold=%0d latency=%0d", exp_resp, exp_data, hold, n);
    endtask

    task automatic aw_phase(input logic [16:0] addr);
        int n;
        AW_ADDR  = addr;
        AW_VALID = 1'b1;
        n = 0;
        while (AW_READY !== 1'b1 && n < 20) begin tick(); n++; end
        check("aw_ready_wait", AW_READY, 1);
        tick();
        AW_VALID = 1'b0;
        check("aw_ready_drop", AW_READY, 0);
    endtask

    task automatic w_phase(input logic [63:0] data, input logic [1:0] exp_resp);
        int n;
        check("w_ready_open", W_READY, 1);
        W_DATA  = data;
        W_VALID = 1'b1;
        B_READY = 1'b1;
        tick();
        W_VALID = 1'b0;
        n = 1;
        while (B_VALID !== 1'b1 && n < 20) begin tick(); n++; end
        check("wr_latency", n, 1 + WR_LAT);
        check("b_resp", B_RESP, exp_resp);
        tick();
        check("b_valid_clear", B_VALID, 0);
        check("aw_ready_after_b", AW_READY, 1);
        $display("write resp=%b data=%h latency=%0d", exp_resp, data, n);
    endtask

    task automatic do_write(input logic [16:0] addr, input logic [63:0] data,
                            input logic [1:0] exp_resp);
        aw_phase(addr);
        w_phase(data, exp_resp);
    endtask

    task automatic do_read(input logic [16:0] addr, input logic [1:0] exp_resp,
                           input logic [63:0] exp_data, input bit chk_data, input int hold);
        ar_phase(addr);
        r_phase(exp_resp, exp_data, chk_data, hold);
    endtask

    initial begin
        rst = 1'b1;
        AR_VALID = 0; AR_ADDR = '0; R_READY = 0;
        AW_VALID = 0; AW_ADDR = '0; W_VALID = 0; W_DATA = '0; B_READY = 0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        #1;
        check("ready_during_release", AR_READY, 0);
        tick();
        check("ar_ready_after_reset", AR_READY, 1);
        check("aw_ready_after_reset", AW_READY, 1);

        // W offered before AW must wait for the address handshake.
        W_DATA  = 64'hDEAD_BEEF_0123_4567;
        W_VALID = 1'b1;
        #1;
        check("w_early_not_ready", W_READY, 0);
        aw_phase(17'h10008);
        w_phase(64'hDEAD_BEEF_0123_4567, 2'b00);

        do_write(17'h10000, 64'h1111_2222_3333_4444, 2'b00);
        do_read(17'h10008, 2'b00, 64'hDEAD_BEEF_0123_4567, 1, 0);

        do_read(17'h10004, 2'b10, 64'h0, 1, 0);
        do_write(17'h0FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10);
        do_read(17'h10000, 2'b00, 64'h1111_2222_3333_4444, 1, 0);

        do_write(17'h107F8, 64'h0BAD_F00D_7777_8888, 2'b00);
        do_read(17'h107F8, 2'b00, 64'h0BAD_F00D_7777_8888, 1, 0);
        do_read(17'h10800, 2'b10, 64'h0, 1, 0);

        do_read(17'h10008, 2'b00, 64'hDEAD_BEEF_0123_4567, 1, 5);

        // Simultaneous AR and AW: read first, write address taken right after.
        AW_ADDR  = 17'h10010;
        AW_VALID = 1'b1;
        AR_ADDR  = 17'h10000;
        AR_VALID = 1'b1;
        #1;
        check("simul_aw_ready", AW_READY, 0);
        check("simul_ar_ready", AR_READY, 1);
        tick();
        AR_VALID = 1'b0;
        check("simul_no_write", W_READY, 0);
        r_phase(2'b00, 64'h1111_2222_3333_4444, 1, 0);
        check("simul_aw_ready_back", AW_READY, 1);
        tick();
        AW_VALID = 1'b0;
        check("simul_aw_taken", W_READY, 1);
        w_phase(64'h5555_6666_7777_8888, 2'b00);
        do_read(17'h10010, 2'b00, 64'h5555_6666_7777_8888, 1, 0);

        // Reset in the middle of the read latency window.
        ar_phase(17'h10000);
        R_READY = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("midrd");
        tick(); tick();
        rst = 1'b0;
        #1;
        check("midrd_release_ar_ready", AR_READY, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrd_no_r_valid", R_VALID, 0);
            check("midrd_ar_ready", AR_READY, 1);
        end
        R_READY = 1'b0;
        $display("reset during read latency");
        do_read(17'h10000, 2'b00, 64'h1111_2222_3333_4444, 1, 0);
        do_read(17'h10008, 2'b00, 64'hDEAD_BEEF_0123_4567, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
